ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage RISC-V pipeline. It consumes the ID/EX register contents, resolves operand forwarding, computes ALU results and branch/jump outcomes, and runs MUL (RV32M low word) on an iterative shift-add unit. It owns the EX/MEM pipeline register that feeds mem_stage, and drives a busy stall upstream while a multiply is in flight.

## Interface
- XLEN, 32, datapath width
- MUL_ITERS, 32, multiply iterations, one product bit per cycle
---
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- valid_id  in  1  ID/EX holds a real instruction
- pc_id, rs1_val_id, rs2_val_id, imm_id  in  32 each  PC, register-file operands, sign-extended immediate
- rs1_id, rs2_id, rd_id  in  5 each  register indices
- alu_op_id  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 PASSB; others yield 0
- alu_src_id  in  1  B operand = imm_id (1) or forwarded rs2 (0)
- funct3_id  in  3  branch condition
- branch_id, jal_id, jalr_id, is_mul_id  in  1 each  instruction class
- mem_read_id, mem_write_id, reg_write_id, mem_to_reg_id  in  1 each  pass-through controls
- wb_rd  in  5, wb_data  in  32, wb_reg_write  in  1  writeback forwarding source
- flush  in  1  kill ID/EX instruction and any in-flight multiply
- alu_res_ex, rs2_val_ex  out  32 each  EX/MEM: result/address, store data
- rd_ex  out  5; mem_read_ex, mem_write_ex, reg_write_ex, mem_to_reg_ex  out  1 each  EX/MEM controls
- branch_taken  out  1, branch_target  out  32  redirect to fetch (combinational)
- ex_busy  out  1  multiply in flight; upstream must hold ID/EX

## Operation
- Forwarding, per source operand: if EX/MEM reg_write_ex && !mem_to_reg_ex && rd_ex!=0 && rd_ex==rsN_id, use alu_res_ex; else if wb_reg_write && wb_rd!=0 && wb_rd==rsN_id, use wb_data; else the register-file value. EX/MEM has priority. Register x0 is never forwarded.
- A = forwarded rs1. B = imm_id if alu_src_id, else forwarded rs2.
- rs2_val_ex always receives forwarded rs2, regardless of alu_src_id.
- Shifts use B[4:0]. SLT is signed, SLTU is unsigned. All arithmetic is mod 2^32.
- Branch: taken if branch_id and the funct3 condition holds on forwarded rs1/rs2. Conditions: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; other codes are never taken.
  - branch_target = pc_id + imm_id.
- JAL: taken; target = pc_id + imm_id. JALR: taken; target = (A + imm_id) & ~1. Both write pc_id + 4 to alu_res_ex.
- branch_taken is gated by valid_id && !ex_busy && !flush.
- Multiply FSM states IDLE and MUL:
  - IDLE → MUL on valid_id && is_mul_id && !flush. Latch A, B, rd and controls; clear accumulator; count = 0. EX/MEM loads a bubble.
  - In MUL: if the multiplier LSB is set, the accumulator adds the multiplicand. Then multiplicand <<= 1 and multiplier >>= 1; count++.
  - MUL → IDLE after the iteration with count == MUL_ITERS-1. On that edge EX/MEM loads the low 32 product bits with the latched rd and controls.
  - Every other MUL-state edge loads a bubble into EX/MEM.
- Bubble: rd_ex = 0, all EX/MEM control bits = 0, data fields = 0.
- flush: on the next edge EX/MEM loads a bubble and the FSM returns to IDLE, discarding any partial product. flush takes priority over a MUL accept and over MUL completion.
- !valid_id in IDLE: EX/MEM loads a bubble.

## Timing
- Reset (rst_n low at an edge): all EX/MEM outputs 0 and FSM in IDLE. ex_busy = 0 after that edge. Reset mid-multiply aborts it.
- Non-MUL ops: 1-cycle latency. ID/EX sampled at edge N appears on the EX/MEM outputs after edge N.
- ex_busy = (state == MUL). For MUL, it is high for exactly MUL_ITERS cycles after the accept edge.
- MUL accepted at edge E0: result is on the EX/MEM outputs after edge E0+MUL_ITERS (32). There are 32 bubbles in between, counting the accept edge's bubble.
- While ex_busy, ID/EX inputs are ignored, except that flush is honoured.
- Forwarding and branch outputs are combinational within the cycle. No combinational path exists from any input to the EX/MEM outputs.

## Test plan
- Reset with rst_n low for 2 edges → all EX/MEM outputs 0, ex_busy 0, branch_taken 0.
- ADD x5 = x1 + x2 (10 + 32), then SUB x6 = x5 − x3 with x3 = 2, back-to-back → alu_res_ex 42 then 40. The EX/MEM forward is used for x5.
- SW with rs2 = x7 written by WB this cycle (wb_data 42), alu_src_id 1, imm 16, rs1 = 0 → alu_res_ex 16, rs2_val_ex 42, mem_write_ex 1.
- BLT at pc 0x100, rs1 = −1, rs2 = 1, imm 0x20 → branch_taken 1, branch_target 0x120. Repeat with BLTU → branch_taken 0.
- MUL 7 × 6, rd = x5 → ex_busy high for 32 cycles and 32 bubbles. Then alu_res_ex 42, rd_ex 5, reg_write_ex 1. Repeat with 0xFFFFFFFF × 2 → 0xFFFFFFFE.
- MUL accepted, then flush at cycle 10 → ex_busy 0 next cycle, no result is ever written, and the next ADD completes normally.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage of the five-stage RISC-V pipeline: operand forwarding, ALU, branch/jump resolution,
// an iterative shift-add multiplier, and the EX/MEM pipeline register.
module ex_stage #(
    parameter int XLEN      = 32,
    parameter int MUL_ITERS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_id,
    input  logic [XLEN-1:0] pc_id,
    input  logic [XLEN-1:0] rs1_val_id,
    input  logic [XLEN-1:0] rs2_val_id,
    input  logic [XLEN-1:0] imm_id,
    input  logic [4:0]      rs1_id,
    input  logic [4:0]      rs2_id,
    input  logic [4:0]      rd_id,
    input  logic [3:0]      alu_op_id,
    input  logic            alu_src_id,
    input  logic [2:0]      funct3_id,
    input  logic            branch_id,
    input  logic            jal_id,
    input  logic            jalr_id,
    input  logic            is_mul_id,
    input  logic            mem_read_id,
    input  logic            mem_write_id,
    input  logic            reg_write_id,
    input  logic            mem_to_reg_id,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            wb_reg_write,
    input  logic            flush,
    output logic [XLEN-1:0] alu_res_ex,
    output logic [XLEN-1:0] rs2_val_ex,
    output logic [4:0]      rd_ex,
    output logic            mem_read_ex,
    output logic            mem_write_ex,
    output logic            reg_write_ex,
    output logic            mem_to_reg_ex,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target,
    output logic            ex_busy
);

    localparam int CW = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;
    localparam logic [CW-1:0] LAST = CW'(MUL_ITERS - 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] op_a, fwd_b, op_b, alu_out, jump_sum;
    logic [XLEN-1:0] mcand, mplier, acc, acc_next;
    logic [CW-1:0]   count;
    logic [4:0]      mul_rd;
    logic            mul_rw, mul_mtr, mul_mr, mul_mw;
    logic            cond, mul_start, mul_done;

    // A load result in EX/MEM is not available yet, so only ALU results forward from there.
    always_comb begin
        op_a = rs1_val_id;
        if (reg_write_ex && !mem_to_reg_ex && rd_ex != 5'd0 && rd_ex == rs1_id)
            op_a = alu_res_ex;
        else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs1_id)
            op_a = wb_data;
        fwd_b = rs2_val_id;
        if (reg_write_ex && !mem_to_reg_ex && rd_ex != 5'd0 && rd_ex == rs2_id)
            fwd_b = alu_res_ex;
        else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs2_id)
            fwd_b = wb_data;
        op_b = alu_src_id ? imm_id : fwd_b;
    end

    always_comb begin
        alu_out = '0;
        case (alu_op_id)
            4'd0:  alu_out = op_a + op_b;
            4'd1:  alu_out = op_a - op_b;
            4'd2:  alu_out = op_a & op_b;
            4'd3:  alu_out = op_a | op_b;
            4'd4:  alu_out = op_a ^ op_b;
            4'd5:  alu_out = op_a << op_b[4:0];
            4'd6:  alu_out = op_a >> op_b[4:0];
            4'd7:  alu_out = $signed(op_a) >>> op_b[4:0];
            4'd8:  alu_out = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'd9:  alu_out = {{(XLEN-1){1'b0}}, op_a < op_b};
            4'd10: alu_out = op_b;
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (funct3_id)
            3'b000: cond = (op_a == fwd_b);
            3'b001: cond = (op_a != fwd_b);
            3'b100: cond = ($signed(op_a) < $signed(fwd_b));
            3'b101: cond = ($signed(op_a) >= $signed(fwd_b));
            3'b110: cond = (op_a < fwd_b);
            3'b111: cond = (op_a >= fwd_b);
            default: cond = 1'b0;
        endcase
        jump_sum      = op_a + imm_id;
        branch_target = jalr_id ? {jump_sum[XLEN-1:1], 1'b0} : pc_id + imm_id;
        branch_taken  = valid_id && !ex_busy && !flush && (jal_id || jalr_id || (branch_id && cond));
    end

    assign ex_busy   = (state == MUL);
    assign mul_start = valid_id && is_mul_id && !flush;
    assign mul_done  = (count == LAST);
    assign acc_next  = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (mul_start) state_next = MUL;
            MUL:  if (flush || mul_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand <= '0;
            mplier <= '0;
            acc <= '0;
            count <= '0;
            mul_rd <= '0;
            {mul_rw, mul_mtr, mul_mr, mul_mw} <= '0;
        end else if (state == IDLE) begin
            if (mul_start) begin
                mcand <= op_a;
                mplier <= op_b;
                acc <= '0;
                count <= '0;
                mul_rd <= rd_id;
                {mul_rw, mul_mtr, mul_mr, mul_mw} <= {reg_write_id, mem_to_reg_id, mem_read_id, mem_write_id};
            end
        end else begin
            acc <= acc_next;
            mcand <= mcand << 1;
            mplier <= mplier >> 1;
            count <= count + CW'(1);
        end
    end

    // Every edge defaults to a bubble; only a live IDLE instruction or a finishing multiply overrides it.
    always_ff @(posedge clk) begin
        alu_res_ex <= '0;
        rs2_val_ex <= '0;
        rd_ex <= '0;
        {mem_read_ex, mem_write_ex, reg_write_ex, mem_to_reg_ex} <= '0;
        if (rst_n && !flush) begin
            if (state == IDLE) begin
                if (valid_id && !is_mul_id) begin
                    alu_res_ex <= (jal_id || jalr_id) ? pc_id + XLEN'(4) : alu_out;
                    rs2_val_ex <= fwd_b;
                    rd_ex <= rd_id;
                    {mem_read_ex, mem_write_ex, reg_write_ex, mem_to_reg_ex} <=
                        {mem_read_id, mem_write_id, reg_write_id, mem_to_reg_id};
                end
            end else if (mul_done) begin
                alu_res_ex <= acc_next;
                rd_ex <= mul_rd;
                {mem_read_ex, mem_write_ex, reg_write_ex, mem_to_reg_ex} <= {mul_mr, mul_mw, mul_rw, mul_mtr};
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed table, randomized forwarding/branch traffic against a
// behavioural model, and hand-written multiply, flush and reset sequences.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_id;
    logic [31:0] pc_id, rs1_val_id, rs2_val_id, imm_id;
    logic [4:0]  rs1_id, rs2_id, rd_id;
    logic [3:0]  alu_op_id;
    logic        alu_src_id;
    logic [2:0]  funct3_id;
    logic        branch_id, jal_id, jalr_id, is_mul_id;
    logic        mem_read_id, mem_write_id, reg_write_id, mem_to_reg_id;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_reg_write;
    logic        flush;
    logic [31:0] alu_res_ex, rs2_val_ex, branch_target;
    logic [4:0]  rd_ex;
    logic        mem_read_ex, mem_write_ex, reg_write_ex, mem_to_reg_ex;
    logic        branch_taken, ex_busy;

    int checks = 0;
    int fails  = 0;

    // Model of what the EX/MEM register should currently hold.
    logic [31:0] m_res, m_rs2;
    logic [4:0]  m_rd;
    logic        m_rw, m_mtr, m_mr, m_mw;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        use_imm;
        logic [31:0] expect_res;
    } alu_vec_t;

    alu_vec_t vecs[13];

    ex_stage dut (
        .clk(clk), .rst_n(rst_n), .valid_id(valid_id), .pc_id(pc_id),
        .rs1_val_id(rs1_val_id), .rs2_val_id(rs2_val_id), .imm_id(imm_id),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id), .alu_op_id(alu_op_id),
        .alu_src_id(alu_src_id), .funct3_id(funct3_id), .branch_id(branch_id),
        .jal_id(jal_id), .jalr_id(jalr_id), .is_mul_id(is_mul_id),
        .mem_read_id(mem_read_id), .mem_write_id(mem_write_id),
        .reg_write_id(reg_write_id), .mem_to_reg_id(mem_to_reg_id),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_reg_write(wb_reg_write), .flush(flush),
        .alu_res_ex(alu_res_ex), .rs2_val_ex(rs2_val_ex), .rd_ex(rd_ex),
        .mem_read_ex(mem_read_ex), .mem_write_ex(mem_write_ex),
        .reg_write_ex(reg_write_ex), .mem_to_reg_ex(mem_to_reg_ex),
        .branch_taken(branch_taken), .branch_target(branch_target), .ex_busy(ex_busy)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: actual %h expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        valid_id = 0; pc_id = 0; rs1_val_id = 0; rs2_val_id = 0; imm_id = 0;
        rs1_id = 0; rs2_id = 0; rd_id = 0; alu_op_id = 0; alu_src_id = 0; funct3_id = 0;
        branch_id = 0; jal_id = 0; jalr_id = 0; is_mul_id = 0;
        mem_read_id = 0; mem_write_id = 0; reg_write_id = 0; mem_to_reg_id = 0;
        wb_rd = 0; wb_data = 0; wb_reg_write = 0; flush = 0;
    endtask

    task automatic apply_stimulus(input alu_vec_t v);
        clear_inputs();
        valid_id = 1; rs1_id = 5'd1; rs2_id = 5'd2; rd_id = 5'd10; reg_write_id = 1;
        alu_op_id = v.op; rs1_val_id = v.a;
        if (v.use_imm) begin alu_src_id = 1; imm_id = v.b; end
        else rs2_val_id = v.b;
    endtask

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ext;
        int sh;
        sh = int'(b % 32);
        ext = {{32{a[31]}}, a};
        case (op)
            4'd0:  return a + b;
            4'd1:  return a + (~b + 32'd1);
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a * (32'd1 << sh);
            4'd6:  return a / (32'd1 << sh);
            4'd7:  return 32'(ext >> sh);
            4'd8:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic br_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a; sb = b;
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] fwd_model(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 0) return rf;
        if (m_rw && !m_mtr && m_rd == idx) return m_res;
        if (wb_reg_write && wb_rd == idx) return wb_data;
        return rf;
    endfunction

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        logic [63:0] prod;
        prod = 64'(a) * 64'(b);
        clear_inputs();
        tick();
        valid_id = 1; is_mul_id = 1; rs1_id = 5'd1; rs2_id = 5'd2; rd_id = rd;
        rs1_val_id = a; rs2_val_id = b; reg_write_id = 1;
        tick();
        check_output("mul_busy_accept", ex_busy, 1);
        check_output("mul_bubble_accept", {alu_res_ex[7:0], rd_ex, reg_write_ex}, 0);
        // Unrelated traffic during the multiply must be ignored.
        is_mul_id = 0; rd_id = 5'd9; rs1_val_id = 32'h55; rs2_val_id = 32'h66;
        for (int i = 1; i < 32; i++) begin
            tick();
            check_output("mul_busy", ex_busy, 1);
            check_output("mul_bubble", {rd_ex, reg_write_ex, mem_write_ex}, 0);
        end
        tick();
        check_output("mul_busy_done", ex_busy, 0);
        check_output("mul_result", alu_res_ex, prod[31:0]);
        check_output("mul_rd", rd_ex, rd);
        check_output("mul_reg_write", reg_write_ex, 1);
        clear_inputs();
    endtask

    initial begin
        logic [31:0] a, b2, bop, exp_res, exp_tgt;
        logic        exp_taken, live, bad;
        logic [63:0] prod;

        vecs[0]  = '{"add",    4'd0,  32'd10,        32'd32,        1'b0, 32'd42};
        vecs[1]  = '{"sub",    4'd1,  32'd5,         32'd7,         1'b0, 32'hFFFF_FFFE};
        vecs[2]  = '{"and",    4'd2,  32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 32'h00F0_1200};
        vecs[3]  = '{"or",     4'd3,  32'hF000_0001, 32'h0000_0010, 1'b0, 32'hF000_0011};
        vecs[4]  = '{"xor",    4'd4,  32'hFFFF_0000, 32'hFF00_FF00, 1'b0, 32'h00FF_FF00};
        vecs[5]  = '{"sll",    4'd5,  32'd1,         32'h23,        1'b1, 32'd8};
        vecs[6]  = '{"srl",    4'd6,  32'h8000_0000, 32'd4,         1'b0, 32'h0800_0000};
        vecs[7]  = '{"sra",    4'd7,  32'h8000_0000, 32'd4,         1'b0, 32'hF800_0000};
        vecs[8]  = '{"slt",    4'd8,  32'hFFFF_FFFF, 32'd1,         1'b0, 32'd1};
        vecs[9]  = '{"sltu",   4'd9,  32'hFFFF_FFFF, 32'd1,         1'b0, 32'd0};
        vecs[10] = '{"passb",  4'd10, 32'd99,        32'h1234,      1'b1, 32'h1234};
        vecs[11] = '{"badop",  4'd11, 32'd99,        32'd5,         1'b0, 32'd0};
        vecs[12] = '{"addovf", 4'd0,  32'hFFFF_FFFF, 32'd2,         1'b0, 32'd1};

        clear_inputs();
        rst_n = 0;
        tick();
        tick();
        check_output("rst_alu_res", alu_res_ex, 0);
        check_output("rst_rs2_val", rs2_val_ex, 0);
        check_output("rst_ctrl", {rd_ex, mem_read_ex, mem_write_ex, reg_write_ex, mem_to_reg_ex}, 0);
        check_output("rst_busy", ex_busy, 0);
        check_output("rst_branch", branch_taken, 0);
        rst_n = 1;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            tick();
            check_output({"vec_", vecs[i].name}, alu_res_ex, vecs[i].expect_res);
        end

        // ADD then SUB with x5 forwarded out of EX/MEM.
        clear_inputs(); tick();
        valid_id = 1; reg_write_id = 1; rs1_id = 1; rs1_val_id = 10; rs2_id = 2; rs2_val_id = 32; rd_id = 5;
        tick();
        check_output("fwd_add", alu_res_ex, 42);
        rs1_id = 5; rs1_val_id = 32'd999; rs2_id = 3; rs2_val_id = 2; rd_id = 6; alu_op_id = 1;
        tick();
        check_output("fwd_sub", alu_res_ex, 40);
        check_output("fwd_sub_rd", rd_ex, 6);

        // Store whose data comes from writeback.
        clear_inputs();
        valid_id = 1; mem_write_id = 1; alu_src_id = 1; imm_id = 16; rs2_id = 7; rs2_val_id = 32'd3;
        wb_rd = 7; wb_data = 42; wb_reg_write = 1;
        tick();
        check_output("sw_addr", alu_res_ex, 16);
        check_output("sw_data", rs2_val_ex, 42);
        check_output("sw_mem_write", mem_write_ex, 1);

        // BLT / BLTU with -1 vs 1.
        clear_inputs(); tick();
        valid_id = 1; branch_id = 1; pc_id = 32'h100; imm_id = 32'h20; funct3_id = 3'b100;
        rs1_id = 1; rs1_val_id = 32'hFFFF_FFFF; rs2_id = 2; rs2_val_id = 1;
        #1;
        check_output("blt_taken", branch_taken, 1);
        check_output("blt_target", branch_target, 32'h120);
        funct3_id = 3'b110;
        #1;
        check_output("bltu_taken", branch_taken, 0);
        tick();

        run_mul(32'd7, 32'd6, 5'd5);
        run_mul(32'hFFFF_FFFF, 32'd2, 5'd12);
        run_mul($urandom, $urandom, 5'd3);

        // Flush mid-multiply, then a normal ADD, then nothing may ever retire from the killed MUL.
        clear_inputs(); tick();
        valid_id = 1; is_mul_id = 1; rs1_id = 1; rs1_val_id = 7; rs2_id = 2; rs2_val_id = 6; rd_id = 5; reg_write_id = 1;
        tick();
        clear_inputs();
        for (int i = 1; i < 10; i++) tick();
        flush = 1;
        tick();
        flush = 0;
        check_output("flush_busy", ex_busy, 0);
        check_output("flush_bubble", {rd_ex, reg_write_ex}, 0);
        valid_id = 1; reg_write_id = 1; rs1_id = 1; rs1_val_id = 3; rs2_id = 2; rs2_val_id = 4; rd_id = 8;
        tick();
        check_output("post_flush_add", alu_res_ex, 7);
        check_output("post_flush_rd", rd_ex, 8);
        clear_inputs();
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (reg_write_ex || ex_busy) bad = 1;
        end
        check_output("flush_no_writeback", bad, 0);

        // Reset in the middle of a multiply aborts it.
        valid_id = 1; is_mul_id = 1; rs1_id = 1; rs1_val_id = 9; rs2_id = 2; rs2_val_id = 9; rd_id = 4; reg_write_id = 1;
        tick();
        clear_inputs();
        for (int i = 0; i < 5; i++) tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        check_output("rst_mid_mul_busy", ex_busy, 0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (reg_write_ex || ex_busy) bad = 1;
        end
        check_output("rst_no_writeback", bad, 0);

        // Random ALU/branch/jump traffic with forwarding hazards over a small register window.
        clear_inputs(); tick();
        m_res = 0; m_rs2 = 0; m_rd = 0; {m_rw, m_mtr, m_mr, m_mw} = 0;
        for (int n = 0; n < 300; n++) begin
            int cls;
            clear_inputs();
            valid_id = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 9) == 0);
            pc_id = $urandom & ~32'd3;
            rs1_val_id = $urandom;
            rs2_val_id = ($urandom_range(0, 3) == 0) ? rs1_val_id : $urandom;
            imm_id = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 40);
            rs1_id = 5'($urandom_range(0, 3)); rs2_id = 5'($urandom_range(0, 3)); rd_id = 5'($urandom_range(0, 3));
            alu_op_id = 4'($urandom_range(0, 15)); alu_src_id = 1'($urandom_range(0, 1));
            funct3_id = 3'($urandom_range(0, 7));
            cls = $urandom_range(0, 3);
            branch_id = (cls == 1); jal_id = (cls == 2); jalr_id = (cls == 3);
            reg_write_id = 1'($urandom_range(0, 1)); mem_to_reg_id = 1'($urandom_range(0, 1));
            mem_read_id = 1'($urandom_range(0, 1)); mem_write_id = 1'($urandom_range(0, 1));
            wb_reg_write = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 3)); wb_data = $urandom;

            a = fwd_model(rs1_id, rs1_val_id);
            b2 = fwd_model(rs2_id, rs2_val_id);
            bop = alu_src_id ? imm_id : b2;
            exp_taken = valid_id && !flush && (jal_id || jalr_id || (branch_id && br_model(funct3_id, a, b2)));
            exp_tgt = jalr_id ? ((a + imm_id) & 32'hFFFF_FFFE) : pc_id + imm_id;
            exp_res = (jal_id || jalr_id) ? pc_id + 32'd4 : alu_model(alu_op_id, a, bop);
            live = valid_id && !flush;
            #1;
            check_output("rand_taken", branch_taken, exp_taken);
            if (exp_taken) check_output("rand_target", branch_target, exp_tgt);
            tick();
            if (live) begin
                m_res = exp_res; m_rs2 = b2; m_rd = rd_id;
                {m_rw, m_mtr, m_mr, m_mw} = {reg_write_id, mem_to_reg_id, mem_read_id, mem_write_id};
            end else begin
                m_res = 0; m_rs2 = 0; m_rd = 0; {m_rw, m_mtr, m_mr, m_mw} = 0;
            end
            check_output("rand_res", alu_res_ex, m_res);
            check_output("rand_rs2", rs2_val_ex, m_rs2);
            check_output("rand_ctrl", {rd_ex, reg_write_ex, mem_to_reg_ex, mem_read_ex, mem_write_ex},
                         {m_rd, m_rw, m_mtr, m_mr, m_mw});
            check_output("rand_busy", ex_busy, 0);
        end

        // A random multiply where the operand is forwarded from the last random result.
        clear_inputs();
        valid_id = 1; reg_write_id = 1; rs1_val_id = $urandom; rd_id = 5'd20;
        prod = 64'(rs1_val_id) * 64'(32'd3);
        tick();
        valid_id = 1; is_mul_id = 1; reg_write_id = 1; rs1_id = 5'd20; rs1_val_id = 0;
        rs2_id = 5'd21; rs2_val_id = 3; rd_id = 5'd22;
        tick();
        clear_inputs();
        for (int i = 0; i < 32; i++) tick();
        check_output("mul_fwd_result", alu_res_ex, prod[31:0]);
        check_output("mul_fwd_rd", rd_ex, 22);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
